fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end of the 5-stage pipelined core. Owns the program counter, drives the synchronous instruction ROM (one-cycle read latency), and buffers returned instructions, each tagged with its PC, in a small prefetch queue. The queue feeds the IF/ID pipeline register. Decode back-pressure (`stall`) and taken-branch redirects from execute are absorbed here, so the ROM never returns an instruction with nowhere to go.

## Interface
- `PC_W`, 16, PC / ROM address width (word addressed)
- `INST_W`, 26, instruction width
- `DEPTH`, 4, prefetch queue entries (power of two, ≥2)
- `RESET_PC`, 0, first fetch address after reset

- `clk`  in  1  clock. One clock; every register updates on its rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `rom_addr`  out  PC_W  ROM address; always equals `fetch_pc`
- `rom_q`  in  INST_W  ROM data; valid the cycle after its address is issued
- `redirect`  in  1  taken branch/jump; flush and restart
- `redirect_pc`  in  PC_W  restart address, sampled when `redirect`=1
- `stall`  in  1  IF/ID cannot accept this cycle
- `inst_valid`  out  1  queue head is valid
- `inst`  out  INST_W  head instruction; 0 when `inst_valid`=0
- `inst_pc`  out  PC_W  PC of the head instruction; 0 when `inst_valid`=0
- `queue_level`  out  $clog2(DEPTH+1)  occupied queue entries

## Operation
- State: `fetch_pc`, in-flight flag `if_v` plus `if_pc`, circular queue (`rd_ptr`, `wr_ptr`, `count`).
- Issue: the cycle issues a fetch when `!redirect && (count + if_v) < DEPTH`. On issue, at the edge: `if_v`<=1, `if_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+1 (mod 2^PC_W, so 0xFFFF wraps to 0x0000). When the cycle does not issue, `if_v`<=0 and `fetch_pc` holds.
- Return: when `if_v`=1, `{rom_q, if_pc}` is pushed at `wr_ptr` that cycle, unless `redirect`=1.
- Pop: `inst_valid && !stall` advances `rd_ptr`. Push and pop may occur in the same cycle; `count` then holds.
- The issue rule reserves a slot for every in-flight fetch, so a push never finds the queue full. An overflow is a design error.
- Redirect (highest priority): at the edge, `count`, `rd_ptr`, `wr_ptr` and `if_v` clear, and `fetch_pc`<=`redirect_pc`. No pop, push or issue takes effect in that cycle, whatever `stall` is. A redirect in back-to-back cycles uses the last `redirect_pc`.
- `stall` held high: fetching continues until `count + if_v` = DEPTH, then pauses. Nothing is lost or duplicated.

## Timing
- Reset values: `fetch_pc`=`RESET_PC` (therefore `rom_addr`=`RESET_PC`), `if_v`=0, pointers 0, `count` 0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `queue_level`=0.
- Reset asserted mid-operation behaves exactly like reset from power-up: queue contents and any in-flight fetch are discarded.
- Cycle R is the first cycle with `rst` low; reset-to-first-instruction latency is 3 cycles:
  - R: issues `RESET_PC`.
  - R+1: `rom_q` valid and pushed.
  - R+2: `inst_valid`=1.
- Redirect asserted in cycle T gives the same latency: T+1 issues `redirect_pc`, and `inst_valid` with `inst_pc`=`redirect_pc` appears in T+3.
- Steady state with no stall: one instruction per cycle.
- Outputs come from queue storage and registers only. There is no combinational path from `stall` or `redirect` to `inst*`.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When `count`=0, `if_v`=1 and `redirect`=0, `rom_q`/`if_pc` drive `inst`/`inst_pc` directly and `inst_valid`=1 in the return cycle.
  - If that instruction is popped (`stall`=0) it is not written into the queue. Otherwise it is pushed as usual.
  - Reset and redirect latency drop to 2 cycles.
- `FETCH_BYPASS_EN` undefined: outputs come from the queue only, with the latencies in Timing.

## Test plan
- Reset with `RESET_PC`=0 and `stall`=0 and ROM[n]=n, then release → `inst_valid` first in R+2 (R+1 with bypass), `inst_pc` 0,1,2,3… on consecutive cycles, `inst`=`inst_pc`.
- `stall` high from R onward → `queue_level` saturates at 3 with one fetch in flight, then 4. `rom_addr` stops at 4. After `stall` drops, PCs 0..7 are delivered with no gap or duplicate.
- Redirect to 0x0040 while the queue holds 3 entries and a fetch is in flight → next delivered `inst_pc`=0x0040 in T+3. None of the old entries appear.
- Redirect and `stall` asserted in the same cycle with the queue full → queue empties, and 0x0100 is delivered once `stall` clears.
- `redirect_pc`=0xFFFE with no stall → PCs 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `rst` pulsed for one cycle mid-stream → all outputs return to their reset values the next cycle, and fetching restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, synchronous ROM interface and a prefetch queue of PC-tagged instructions.
// Define FETCH_BYPASS_EN to forward the returning ROM word straight to the outputs when the queue is empty.
module fetch_unit #(
  parameter int unsigned           PC_W     = 16,
  parameter int unsigned           INST_W   = 26,
  parameter int unsigned           DEPTH    = 4,
  parameter logic [PC_W-1:0]       RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [PC_W-1:0]              rom_addr,
  input  logic [INST_W-1:0]            rom_q,
  input  logic                         redirect,
  input  logic [PC_W-1:0]              redirect_pc,
  input  logic                         stall,
  output logic                         inst_valid,
  output logic [INST_W-1:0]            inst,
  output logic [PC_W-1:0]              inst_pc,
  output logic [$clog2(DEPTH+1)-1:0]   queue_level
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   if_pc_q, if_pc_d;
  logic              if_v_q, if_v_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [INST_W-1:0] q_inst_q [DEPTH];
  logic [INST_W-1:0] q_inst_d [DEPTH];
  logic [PC_W-1:0]   q_pc_q   [DEPTH];
  logic [PC_W-1:0]   q_pc_d   [DEPTH];

  logic              queue_ne;
  logic              bypass_hit;
  logic              pop;
  logic              pop_queue;
  logic              push;
  logic              issue;
  logic [CW:0]       occupancy;

  always_comb begin
    queue_ne = (count_q != '0);
`ifdef FETCH_BYPASS_EN
    bypass_hit = !queue_ne && if_v_q && !redirect;
`else
    bypass_hit = 1'b0;
`endif
    inst_valid = queue_ne || bypass_hit;
    inst       = '0;
    inst_pc    = '0;
    if (queue_ne) begin
      inst    = q_inst_q[rd_ptr_q];
      inst_pc = q_pc_q[rd_ptr_q];
    end else if (bypass_hit) begin
      inst    = rom_q;
      inst_pc = if_pc_q;
    end
    rom_addr    = fetch_pc_q;
    queue_level = count_q;
  end

  // A bypassed word that is consumed this cycle never occupies a queue slot.
  always_comb begin
    pop       = inst_valid && !stall && !redirect;
    pop_queue = pop && queue_ne;
    push      = if_v_q && !redirect && !(bypass_hit && pop);
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, if_v_q};
    issue     = !redirect && (occupancy < (CW + 1)'(DEPTH));
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if_pc_d    = if_pc_q;
    if_v_d     = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    q_inst_d   = q_inst_q;
    q_pc_d     = q_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        if_v_d     = 1'b1;
        if_pc_d    = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_W'(1);
      end
      if (push) begin
        q_inst_d[wr_ptr_q] = rom_q;
        q_pc_d[wr_ptr_q]   = if_pc_q;
        wr_ptr_d           = wr_ptr_q + PW'(1);
      end
      if (pop_queue) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop_queue})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      if_pc_q    <= '0;
      if_v_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_inst_q[i] <= '0;
        q_pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if_pc_q    <= if_pc_d;
      if_v_q     <= if_v_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      q_inst_q   <= q_inst_d;
      q_pc_q     <= q_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stall/redirect/reset traffic,
// compared every cycle against a queue-based model of the fetch front end.
module tb_fetch_unit;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned INST_W = 26;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic [PC_W-1:0]   rom_addr;
  logic [INST_W-1:0] rom_q;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              stall;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic [2:0]        queue_level;

  fetch_unit #(
    .PC_W(16),
    .INST_W(26),
    .DEPTH(4),
    .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rom_addr(rom_addr),
    .rom_q(rom_q),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc(inst_pc),
    .queue_level(queue_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: sequence of PCs waiting in the queue, one in-flight fetch, fetch PC.
  logic [PC_W-1:0] mq[$];
  logic            m_ifv   = 1'b0;
  logic [PC_W-1:0] m_ifpc  = '0;
  logic [PC_W-1:0] m_fpc   = '0;
  logic            m_known = 1'b0;

  function automatic logic [INST_W-1:0] rom_f(input logic [PC_W-1:0] a);
    return {a[9:0] ^ 10'h2B7, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic red, input logic [PC_W-1:0] rpc, input logic st);
    logic            byp;
    logic            exp_v;
    logic [PC_W-1:0] exp_pc;
    logic [INST_W-1:0] exp_inst;
    logic [PC_W-1:0] addr_s;
    logic            iss;
    logic            pop;
    rst = r;
    redirect = red;
    redirect_pc = rpc;
    stall = st;
    #1;
    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = (mq.size() == 0) && m_ifv && !red;
`endif
    exp_v    = (mq.size() != 0) || byp;
    exp_pc   = '0;
    exp_inst = '0;
    if (mq.size() != 0) begin
      exp_pc   = mq[0];
      exp_inst = rom_f(mq[0]);
    end else if (byp) begin
      exp_pc   = m_ifpc;
      exp_inst = rom_f(m_ifpc);
    end
    if (m_known) begin
      check("inst_valid",  32'(inst_valid),  32'(exp_v));
      check("inst_pc",     32'(inst_pc),     32'(exp_pc));
      check("inst",        32'(inst),        32'(exp_inst));
      check("queue_level", 32'(queue_level), mq.size());
      check("rom_addr",    32'(rom_addr),    32'(m_fpc));
    end
    addr_s = rom_addr;
    iss = (mq.size() + int'(m_ifv)) < DEPTH;
    pop = exp_v && !st;
    if (r) begin
      mq.delete();
      m_ifv   = 1'b0;
      m_ifpc  = '0;
      m_fpc   = '0;
      m_known = 1'b1;
    end else if (red) begin
      mq.delete();
      m_ifv = 1'b0;
      m_fpc = rpc;
    end else begin
      if (!(byp && pop)) begin
        if (pop) void'(mq.pop_front());
        if (m_ifv) mq.push_back(m_ifpc);
      end
      m_ifv = iss;
      if (iss) begin
        m_ifpc = m_fpc;
        m_fpc  = m_fpc + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    rom_q = rom_f(addr_s);
  endtask

  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    stall = 1'b0;
    rom_q = '0;

    // Reset, then free-running fetch.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);

    // Stall from the first cycle out of reset: queue saturates, fetch PC stops at 4.
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    check("stall_level_sat", 32'(queue_level), 32'd4);
    check("stall_addr_stop", 32'(rom_addr), 32'd4);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0);

    // Redirect with three entries queued and one fetch in flight.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    step(0, 1, 16'h0040, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

    // Redirect together with stall while the queue is full.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    step(0, 1, 16'h0100, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

    // Back-to-back redirects; the second address wins. Then wrap past 0xFFFF.
    step(0, 1, 16'h1234, 0);
    step(0, 1, 16'hFFFE, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

    // One-cycle reset pulse mid-stream.
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic            r;
      logic            red;
      logic            st;
      logic [PC_W-1:0] rpc;
      r   = ($urandom_range(0, 39) == 0);
      red = ($urandom_range(0, 15) == 0);
      st  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 16'hFFFC + 16'($urandom_range(0, 3));
      else rpc = 16'($urandom);
      step(r, red, rpc, st);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
